// File: rtl/sram_bus_arbiter.sv
// Two-requester arbiter for the multiplexed 8-bit SRAM bus: address latch, data setup, write strobe, hold.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise dbg has fixed priority over cpu.
module sram_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [6:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [3:0] cpu_rdata,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [6:0] dbg_addr,
  input  logic [3:0] dbg_wdata,
  output logic       dbg_ack,
  output logic [3:0] dbg_rdata,
  output logic [7:0] bus_out,
  input  logic [3:0] bus_in,
  output logic       busy,
  output logic       grant_dbg
);

  typedef enum logic [2:0] {IDLE, ADDR, SETUP, STROBE, HOLD} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic [7:0] BUS_IDLE  = 8'h30;

  state_t     state_reg;
  logic [6:0] addr_reg;
  logic       we_reg;
  logic [3:0] wdata_reg;
  logic [2:0] wait_cnt_reg;

  logic       pick_dbg;
  logic [6:0] sel_addr;
  logic       sel_we;
  logic [3:0] sel_wdata;

`ifdef SRAM_ARB_RR_EN
  // grant_dbg remembers the last owner, so a tie goes to the other side
  always_comb pick_dbg = dbg_req && (!cpu_req || !grant_dbg);
`else
  always_comb pick_dbg = dbg_req;
`endif

  always_comb begin
    sel_addr  = cpu_addr;
    sel_we    = cpu_we;
    sel_wdata = cpu_wdata;
    if (pick_dbg) begin
      sel_addr  = dbg_addr;
      sel_we    = dbg_we;
      sel_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    assert (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 7)
      else $error("sram_bus_arbiter: WAIT_CYCLES out of range 1..7");
  end

  // Outputs are assigned from the next state so every pin is a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bus_out      <= BUS_IDLE;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
      cpu_rdata    <= 4'h0;
      dbg_rdata    <= 4'h0;
      busy         <= 1'b0;
      grant_dbg    <= 1'b0;
      addr_reg     <= 7'h00;
      we_reg       <= 1'b0;
      wdata_reg    <= 4'h0;
      wait_cnt_reg <= 3'd0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            state_reg <= ADDR;
            busy      <= 1'b1;
            grant_dbg <= pick_dbg;
            addr_reg  <= sel_addr;
            we_reg    <= sel_we;
            // reads drive zero on the data pins for the whole transaction
            wdata_reg <= sel_we ? sel_wdata : 4'h0;
            bus_out   <= {1'b1, sel_addr};
          end else begin
            bus_out <= BUS_IDLE;
          end
        end
        ADDR: begin
          state_reg    <= SETUP;
          wait_cnt_reg <= WAIT_INIT;
          bus_out      <= {4'b0010, wdata_reg};
        end
        SETUP: begin
          if (wait_cnt_reg <= 3'd1) begin
            if (we_reg) begin
              state_reg <= STROBE;
              bus_out   <= {4'b0000, wdata_reg};
            end else begin
              state_reg <= HOLD;
              bus_out   <= {4'b0011, wdata_reg};
              if (grant_dbg) begin
                dbg_rdata <= bus_in;
                dbg_ack   <= 1'b1;
              end else begin
                cpu_rdata <= bus_in;
                cpu_ack   <= 1'b1;
              end
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        STROBE: begin
          state_reg <= HOLD;
          bus_out   <= {4'b0011, wdata_reg};
          if (grant_dbg) dbg_ack <= 1'b1;
          else           cpu_ack <= 1'b1;
        end
        HOLD: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          bus_out   <= BUS_IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          bus_out   <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed bus-sequence scenarios plus randomized two-requester traffic
// checked against a transaction-level memory model (execution order = ack order).
module tb_sram_bus_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_en = 1'b1;
  always #5 clk = ~clk;

  // main instance, WAIT_CYCLES = 1
  logic       cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [6:0] cpu_addr = 0, dbg_addr = 0;
  logic [3:0] cpu_wdata = 0, dbg_wdata = 0;
  logic       cpu_ack, dbg_ack, busy, grant_dbg;
  logic [3:0] cpu_rdata, dbg_rdata, bus_in;
  logic [7:0] bus_out;

  // second instance, WAIT_CYCLES = 3
  logic       w3_cpu_req = 0, w3_cpu_we = 0, w3_dbg_req = 0, w3_dbg_we = 0;
  logic [6:0] w3_cpu_addr = 0, w3_dbg_addr = 0;
  logic [3:0] w3_cpu_wdata = 0, w3_dbg_wdata = 0;
  logic       w3_cpu_ack, w3_dbg_ack, w3_busy, w3_grant_dbg;
  logic [3:0] w3_cpu_rdata, w3_dbg_rdata, w3_bus_in;
  logic [7:0] w3_bus_out;

  sram_bus_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .bus_out(bus_out), .bus_in(bus_in), .busy(busy), .grant_dbg(grant_dbg)
  );

  sram_bus_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(w3_cpu_req), .cpu_we(w3_cpu_we), .cpu_addr(w3_cpu_addr), .cpu_wdata(w3_cpu_wdata),
    .cpu_ack(w3_cpu_ack), .cpu_rdata(w3_cpu_rdata),
    .dbg_req(w3_dbg_req), .dbg_we(w3_dbg_we), .dbg_addr(w3_dbg_addr), .dbg_wdata(w3_dbg_wdata),
    .dbg_ack(w3_dbg_ack), .dbg_rdata(w3_dbg_rdata),
    .bus_out(w3_bus_out), .bus_in(w3_bus_in), .busy(w3_busy), .grant_dbg(w3_grant_dbg)
  );

  // External address latch + 4-bit SRAM, one per instance; strobes qualified by bit7 low.
  int         seed;
  logic [3:0] sram1 [128];
  logic [3:0] sram3 [128];
  logic [6:0] lat1, lat3;

  always @(posedge clk) begin
    if (init_en) begin
      for (int a = 0; a < 128; a++) sram1[a] <= 4'((a * 7 + seed) & 15);
    end else if (bus_out[7]) lat1 <= bus_out[6:0];
    else if (!bus_out[5]) sram1[lat1] <= bus_out[3:0];
  end
  always @(posedge clk) begin
    if (init_en) begin
      for (int a = 0; a < 128; a++) sram3[a] <= 4'((a * 7 + seed) & 15);
    end else if (w3_bus_out[7]) lat3 <= w3_bus_out[6:0];
    else if (!w3_bus_out[5]) sram3[lat3] <= w3_bus_out[3:0];
  end
  assign bus_in    = (!bus_out[7] && !bus_out[4]) ? sram1[lat1] : 4'h0;
  assign w3_bus_in = (!w3_bus_out[7] && !w3_bus_out[4]) ? sram3[lat3] : 4'h0;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] mem_m [128];   // reference memory contents for u_dut
  bit         last_dbg_m;    // reference: last served owner

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus_out, busy, cpu_ack, dbg_ack, grant_dbg} !== {8'h30, 4'b0000}) begin
      errors++;
      $display("FAIL reset_ctrl got bus=%h busy=%b acks=%b%b gnt=%b want bus=30 busy=0 acks=00 gnt=0",
               bus_out, busy, cpu_ack, dbg_ack, grant_dbg);
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h%h want 00", cpu_rdata, dbg_rdata);
    end
    checks++;
    if (w3_bus_out !== 8'h30) begin
      errors++;
      $display("FAIL reset_w3_bus got %h want 30", w3_bus_out);
    end
    for (int a = 0; a < 128; a++) mem_m[a] = 4'((a * 7 + seed) & 15);
    last_dbg_m = 1'b0;
    rst = 1'b0;
    init_en = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h85, 8'h2A, 8'h0A, 8'h3A};
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'h05; cpu_wdata = 4'hA;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_out !== exp_seq[i] || cpu_ack !== (i == 3) || dbg_ack !== 1'b0) begin
        errors++;
        $display("FAIL write_seq cycle %0d got bus=%h cpu_ack=%b dbg_ack=%b want bus=%h cpu_ack=%b dbg_ack=0",
                 i + 1, bus_out, cpu_ack, dbg_ack, exp_seq[i], i == 3);
      end
    end
    cpu_req = 0;
    mem_m[5] = 4'hA;
    last_dbg_m = 1'b0;
    tick();
    checks++;
    if (bus_out !== 8'h30 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_idle got bus=%h busy=%b ack=%b want 30 0 0", bus_out, busy, cpu_ack);
    end
    checks++;
    if (sram1[5] !== 4'hA) begin
      errors++;
      $display("FAIL write_mem got %h want a", sram1[5]);
    end
  endtask

  task automatic test_cpu_read();
    logic [7:0] exp_seq [3];
    int strobes = 0;
    exp_seq = '{8'h85, 8'h20, 8'h30};
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'h05; cpu_wdata = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!bus_out[7] && !bus_out[5]) strobes++;
      checks++;
      if (bus_out !== exp_seq[i] || cpu_ack !== (i == 2)) begin
        errors++;
        $display("FAIL read_seq cycle %0d got bus=%h ack=%b want bus=%h ack=%b",
                 i + 1, bus_out, cpu_ack, exp_seq[i], i == 2);
      end
    end
    checks++;
    if (cpu_rdata !== mem_m[5]) begin
      errors++;
      $display("FAIL read_data got %h want %h", cpu_rdata, mem_m[5]);
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL read_no_strobe got %0d write strobes want 0", strobes);
    end
    cpu_req = 0;
    last_dbg_m = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    bit win_dbg;
    int cpu_n = 0, dbg_n = 0, cpu_cyc = -1, dbg_cyc = -1, both = 0;
    logic [3:0] cpu_got = 0, dbg_got = 0;
    win_dbg = RR ? !last_dbg_m : 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'h11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (cpu_ack && dbg_ack) both++;
      if (cpu_ack) begin
        cpu_n++; cpu_cyc = c; cpu_got = cpu_rdata; cpu_req = 0;
      end
      if (dbg_ack) begin
        dbg_n++; dbg_cyc = c; dbg_got = dbg_rdata; dbg_req = 0;
      end
    end
    checks++;
    if (cpu_n !== 1 || dbg_n !== 1 || both !== 0) begin
      errors++;
      $display("FAIL tie_ack_count got cpu=%0d dbg=%0d both=%0d want 1 1 0", cpu_n, dbg_n, both);
    end
    checks++;
    if (dbg_cyc !== (win_dbg ? 3 : 7) || cpu_cyc !== (win_dbg ? 7 : 3)) begin
      errors++;
      $display("FAIL tie_order got dbg_cycle=%0d cpu_cycle=%0d want %0d %0d",
               dbg_cyc, cpu_cyc, win_dbg ? 3 : 7, win_dbg ? 7 : 3);
    end
    checks++;
    if (cpu_got !== mem_m[7'h10] || dbg_got !== mem_m[7'h11]) begin
      errors++;
      $display("FAIL tie_rdata got cpu=%h dbg=%h want %h %h",
               cpu_got, dbg_got, mem_m[7'h10], mem_m[7'h11]);
    end
    checks++;
    if (grant_dbg !== !win_dbg) begin
      errors++;
      $display("FAIL tie_grant got %b want %b", grant_dbg, !win_dbg);
    end
    last_dbg_m = !win_dbg;
  endtask

  task automatic test_wait3();
    logic [7:0] exp_seq [6];
    exp_seq = '{8'hFF, 8'h23, 8'h23, 8'h23, 8'h03, 8'h33};
    w3_dbg_req = 1; w3_dbg_we = 1; w3_dbg_addr = 7'h7F; w3_dbg_wdata = 4'h3;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (w3_bus_out !== exp_seq[i] || w3_dbg_ack !== (i == 5) || w3_cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL wait3_seq cycle %0d got bus=%h dbg_ack=%b cpu_ack=%b want bus=%h dbg_ack=%b cpu_ack=0",
                 i + 1, w3_bus_out, w3_dbg_ack, w3_cpu_ack, exp_seq[i], i == 5);
      end
    end
    w3_dbg_req = 0;
    tick();
    checks++;
    if (sram3[7'h7F] !== 4'h3 || w3_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait3_mem got mem=%h busy=%b want 3 0", sram3[7'h7F], w3_busy);
    end
  endtask

  task automatic test_rst_strobe();
    logic [3:0] old_val;
    int diffs = 0;
    int got = 0;
    old_val = mem_m[7'h22];
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'h22; cpu_wdata = ~old_val;
    tick(); tick(); tick();
    checks++;
    if (bus_out !== {4'h0, ~old_val}) begin
      errors++;
      $display("FAIL rst_pre_strobe got %h want %h", bus_out, {4'h0, ~old_val});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_out !== 8'h30 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got bus=%h busy=%b ack=%b want 30 0 0", bus_out, busy, cpu_ack);
    end
    tick();
    checks++;
    if (bus_out !== 8'h30 || cpu_ack !== 1'b0 || grant_dbg !== 1'b0) begin
      errors++;
      $display("FAIL rst_held got bus=%h ack=%b gnt=%b want 30 0 0", bus_out, cpu_ack, grant_dbg);
    end
    rst = 1'b0;
    cpu_req = 0;
    last_dbg_m = 1'b0;
    tick();
    for (int a = 0; a < 128; a++) if (sram1[a] !== mem_m[a]) diffs++;
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL rst_no_glitch got %0d changed words want 0", diffs);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'h22;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (cpu_ack) begin
        got = 1;
        cpu_req = 0;
        checks++;
        if (cpu_rdata !== old_val) begin
          errors++;
          $display("FAIL rst_readback got %h want %h", cpu_rdata, old_val);
        end
      end
    end
    if (got == 0) begin
      checks++;
      errors++;
      $display("FAIL rst_readback_timeout got no ack want ack");
      cpu_req = 0;
    end
    tick();
  endtask

  task automatic test_addr_change();
    logic [3:0] d;
    d = ~mem_m[7'h40];
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'h40; cpu_wdata = d;
    tick();
    checks++;
    if (bus_out !== 8'hC0) begin
      errors++;
      $display("FAIL chg_addr_phase got %h want c0", bus_out);
    end
    tick();
    cpu_addr = 7'h41; cpu_wdata = ~d; cpu_req = 0;
    tick();
    checks++;
    if (bus_out !== {4'h0, d}) begin
      errors++;
      $display("FAIL chg_strobe got %h want %h", bus_out, {4'h0, d});
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL chg_ack got %b want 1", cpu_ack);
    end
    tick();
    checks++;
    if (sram1[7'h40] !== d || sram1[7'h41] !== mem_m[7'h41]) begin
      errors++;
      $display("FAIL chg_mem got [40]=%h [41]=%h want %h %h",
               sram1[7'h40], sram1[7'h41], d, mem_m[7'h41]);
    end
    mem_m[7'h40] = d;
    last_dbg_m = 1'b0;
  endtask

  task automatic cpu_traffic(input int n);
    logic [3:0] held;
    logic [6:0] a;
    logic [3:0] d;
    logic       w;
    int         got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 3)) tick();
      a = 7'($urandom_range(0, 15)); d = 4'($urandom); w = 1'($urandom);
      cpu_addr = a; cpu_wdata = d; cpu_we = w; cpu_req = 1;
      held = cpu_rdata;
      got = 0;
      for (int c = 0; c < 400 && got == 0; c++) begin
        tick();
        checks++;
        if (cpu_ack) begin
          got = 1;
          cpu_req = 0;
          last_dbg_m = 1'b0;
          if (w) begin
            mem_m[a] = d;
            if (cpu_rdata !== held) begin
              errors++;
              $display("FAIL rnd_cpu_wr_rdata got %h want %h", cpu_rdata, held);
            end
          end else if (cpu_rdata !== mem_m[a]) begin
            errors++;
            $display("FAIL rnd_cpu_read addr %h got %h want %h", a, cpu_rdata, mem_m[a]);
          end
        end else if (cpu_rdata !== held) begin
          errors++;
          $display("FAIL rnd_cpu_rdata_stable got %h want %h", cpu_rdata, held);
        end
      end
      if (got == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_cpu_timeout txn %0d got no ack want ack", t);
        cpu_req = 0;
      end
    end
  endtask

  task automatic dbg_traffic(input int n);
    logic [3:0] held;
    logic [6:0] a;
    logic [3:0] d;
    logic       w;
    int         got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 4)) tick();
      a = 7'($urandom_range(0, 15)); d = 4'($urandom); w = 1'($urandom);
      dbg_addr = a; dbg_wdata = d; dbg_we = w; dbg_req = 1;
      held = dbg_rdata;
      got = 0;
      for (int c = 0; c < 400 && got == 0; c++) begin
        tick();
        checks++;
        if (dbg_ack) begin
          got = 1;
          dbg_req = 0;
          last_dbg_m = 1'b1;
          if (cpu_ack) begin
            errors++;
            $display("FAIL rnd_double_ack got cpu_ack=1 dbg_ack=1 want one");
          end
          if (w) mem_m[a] = d;
          else if (dbg_rdata !== mem_m[a]) begin
            errors++;
            $display("FAIL rnd_dbg_read addr %h got %h want %h", a, dbg_rdata, mem_m[a]);
          end
        end else if (dbg_rdata !== held) begin
          errors++;
          $display("FAIL rnd_dbg_rdata_stable got %h want %h", dbg_rdata, held);
        end
      end
      if (got == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_dbg_timeout txn %0d got no ack want ack", t);
        dbg_req = 0;
      end
    end
  endtask

  task automatic test_random();
    fork
      cpu_traffic(25);
      dbg_traffic(25);
    join
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || bus_out !== 8'h30) begin
      errors++;
      $display("FAIL rnd_final_idle got busy=%b bus=%h want 0 30", busy, bus_out);
    end
  endtask

  initial begin
    seed = int'($urandom_range(0, 15));
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_tie();
    tick();
    test_tie();
    tick();
    test_wait3();
    test_rst_strobe();
    test_addr_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
